wbm_byte_cmd: RTL and testbench
===============================

// Module: wbm_byte_cmd
// PURPOSE
//  Byte-stream command parser and single-beat Wishbone master. It sits upstream of the
//  sw_reg_* slaves and is fed by the host link (e.g. UART rx/tx bytes).
//  Each command frame becomes one WB read or write. The block returns a status byte,
//  and for reads the read data, on the tx byte stream.
// PARAMETERS
//  BUS_DATA_WIDTH  32   WB data width; multiple of 8 (8/16/32/64); DB = BUS_DATA_WIDTH/8
//  BUS_ADDR_WIDTH  8    WB address width; AB = ceil(BUS_ADDR_WIDTH/8) address bytes per frame
//  TIMEOUT         255  wb_clk_i cycles to wait for ack/err before aborting; 1..65535
// PORTS
//  wb_clk_i   in   1    single clock for everything
//  wb_rst_i   in   1    synchronous, active-high reset
//  rx_data_i  in   8    command byte in
//  rx_valid_i in   1    rx_data_i valid; byte taken when rx_valid_i & rx_ready_o
//  rx_ready_o out  1    parser accepts a byte this cycle
//  tx_data_o  out  8    response byte out
//  tx_valid_o out  1    tx_data_o valid; held stable until tx_ready_i
//  tx_ready_i in   1    sink accepts tx byte
//  wbm_cyc_o  out  1    WB cycle
//  wbm_stb_o  out  1    WB strobe
//  wbm_we_o   out  1    WB write enable
//  wbm_sel_o  out  DB   byte enables, always all ones
//  wbm_adr_o  out  BUS_ADDR_WIDTH  WB address
//  wbm_dat_o  out  BUS_DATA_WIDTH  WB write data
//  wbm_dat_i  in   BUS_DATA_WIDTH  WB read data
//  wbm_ack_i  in   1    WB ack (the slave holds it high until stb falls)
//  wbm_err_i  in   1    WB error
// BEHAVIOUR
//  Reset: cyc/stb/we = 0, sel = all ones, adr/dat_o = 0, tx_valid_o = 0, tx_data_o = 0,
//    rx_ready_o = 0, state = IDLE, timeout count = 0. Reset mid-frame or mid-cycle aborts silently.
//  Frame: OP, then AB address bytes MSB first, then (write only) DB data bytes MSB first.
//    OP 0x01 = write, 0x02 = read. Any other OP: send single byte 0xE1, return to IDLE.
//    Address bits above BUS_ADDR_WIDTH are dropped.
//  rx_ready_o = 1 only in IDLE/ADDR/DATA. One byte is accepted per cycle, with no bubble.
//  FSM:
//    IDLE -> ADDR on OP byte.
//    ADDR -> DATA (write) or BUS (read) after the AB-th byte.
//    DATA -> BUS after the DB-th byte.
//    BUS: cyc = stb = 1, we = write; timeout count cleared on entry, +1 per cycle.
//      ack -> status 0xA5, latch wbm_dat_i when reading.
//      err -> status 0xEE. err wins if ack and err are high in the same cycle.
//      count == TIMEOUT-1 with no ack/err -> status 0xE0.
//      On any exit, cyc/stb fall in the next cycle. Next state is DROP.
//    DROP: waits until wbm_ack_i == 0 (at most TIMEOUT cycles; then proceeds anyway).
//      -> RESP_STAT.
//    RESP_STAT: tx_valid_o = 1, tx_data_o = status.
//      On handshake: status 0xA5 and read -> RESP_DATA, else -> IDLE.
//    RESP_DATA: sends DB bytes of latched read data MSB first, one per tx handshake -> IDLE.
//  Latency: one cycle from the last frame byte to stb high. One cycle from ack to stb low.
//    tx_valid_o rises one cycle after DROP exits.
//  tx_valid_o is never dropped before tx_ready_i; tx_data_o holds while tx_valid_o & ~tx_ready_i.
//  Byte counters wrap only via FSM reset to 0 on each state entry; there is no partial-frame timeout.
// TESTING
//  1 Write: rx 01 00 DE AD BE EF -> adr=0x00, dat_o=0xDEADBEEF, we=1, sel=0xF, then tx A5.
//  2 Read: slave returns 0x12345678 on ack -> rx 02 00 gives tx A5 12 34 56 78, we=0.
//  3 Timeout: no ack, TIMEOUT=8 -> stb high exactly 8 cycles, then tx E0 only.
//  4 Error: ack+err same cycle on a read -> tx EE only; no data bytes.
//  5 Backpressure: tx_ready_i low 5 cycles during read response -> bytes unchanged, none lost.
//  6 Bad opcode 0x7F -> tx E1. wb_rst_i asserted in the middle of BUS -> next cycle cyc=stb=0,
//    tx_valid_o=0, state IDLE.

Source files
------------

// File: rtl/wbm_byte_cmd.sv
// wbm_byte_cmd: byte-stream command parser driving a single-beat Wishbone master.
// A frame (OP, address bytes, optional write data bytes; all MSB first) becomes
// one WB read or write. The result goes back on the tx byte stream as a status
// byte, followed by the read data when a read completes with ack.
//
// Ports
//   wb_clk_i, wb_rst_i        clock, synchronous active-high reset
//   rx_data_i/valid_i/ready_o command byte stream in (valid/ready handshake)
//   tx_data_o/valid_o/ready_i response byte stream out (valid/ready handshake)
//   wbm_*                     Wishbone master (cyc, stb, we, sel, adr, dat, ack, err)
module wbm_byte_cmd #(
  parameter int BUS_DATA_WIDTH = 32,
  parameter int BUS_ADDR_WIDTH = 8,
  parameter int TIMEOUT        = 255
)(
  input  logic                        wb_clk_i,
  input  logic                        wb_rst_i,
  input  logic [7:0]                  rx_data_i,
  input  logic                        rx_valid_i,
  output logic                        rx_ready_o,
  output logic [7:0]                  tx_data_o,
  output logic                        tx_valid_o,
  input  logic                        tx_ready_i,
  output logic                        wbm_cyc_o,
  output logic                        wbm_stb_o,
  output logic                        wbm_we_o,
  output logic [BUS_DATA_WIDTH/8-1:0] wbm_sel_o,
  output logic [BUS_ADDR_WIDTH-1:0]   wbm_adr_o,
  output logic [BUS_DATA_WIDTH-1:0]   wbm_dat_o,
  input  logic [BUS_DATA_WIDTH-1:0]   wbm_dat_i,
  input  logic                        wbm_ack_i,
  input  logic                        wbm_err_i
);
  localparam int DB = BUS_DATA_WIDTH / 8;
  localparam int AB = (BUS_ADDR_WIDTH + 7) / 8;
  localparam int AW = AB * 8;

  localparam logic [7:0] ST_OK    = 8'hA5;
  localparam logic [7:0] ST_ERR   = 8'hEE;
  localparam logic [7:0] ST_TO    = 8'hE0;
  localparam logic [7:0] ST_BADOP = 8'hE1;

  typedef enum logic [2:0] {
    S_IDLE, S_ADDR, S_DATA, S_BUS, S_DROP, S_STAT, S_RDAT
  } state_t;

  state_t                    state_q, state_d;
  logic [7:0]                bcnt_q, bcnt_d;
  logic [15:0]               tcnt_q, tcnt_d;
  logic                      wr_q, wr_d;
  logic [7:0]                stat_q, stat_d;
  logic [AW-1:0]             adr_q, adr_d;
  logic [BUS_DATA_WIDTH-1:0] wdat_q, wdat_d;
  logic [BUS_DATA_WIDTH-1:0] rdat_q, rdat_d;
  logic                      rx_rdy_q;

  logic rx_fire, tx_fire, t_last;

  assign rx_fire = rx_valid_i & rx_ready_o;
  assign tx_fire = tx_valid_o & tx_ready_i;
  assign t_last  = (tcnt_q == 16'(TIMEOUT - 1));

  always_comb begin
    state_d = state_q;
    bcnt_d  = bcnt_q;
    tcnt_d  = tcnt_q;
    wr_d    = wr_q;
    stat_d  = stat_q;
    adr_d   = adr_q;
    wdat_d  = wdat_q;
    rdat_d  = rdat_q;
    case (state_q)
      S_IDLE: if (rx_fire) begin
        bcnt_d = 8'd0;
        if (rx_data_i == 8'h01) begin
          wr_d = 1'b1; state_d = S_ADDR;
        end else if (rx_data_i == 8'h02) begin
          wr_d = 1'b0; state_d = S_ADDR;
        end else begin
          // wr_d set so the status handshake never branches into read data
          wr_d = 1'b1; stat_d = ST_BADOP; state_d = S_STAT;
        end
      end
      S_ADDR: if (rx_fire) begin
        adr_d  = (adr_q << 8) | AW'(rx_data_i);
        bcnt_d = bcnt_q + 8'd1;
        if (bcnt_q == 8'(AB - 1)) begin
          bcnt_d  = 8'd0;
          tcnt_d  = 16'd0;
          state_d = wr_q ? S_DATA : S_BUS;
        end
      end
      S_DATA: if (rx_fire) begin
        wdat_d = (wdat_q << 8) | BUS_DATA_WIDTH'(rx_data_i);
        bcnt_d = bcnt_q + 8'd1;
        if (bcnt_q == 8'(DB - 1)) begin
          bcnt_d  = 8'd0;
          tcnt_d  = 16'd0;
          state_d = S_BUS;
        end
      end
      S_BUS: begin
        tcnt_d = tcnt_q + 16'd1;
        // priority: err over ack over timeout
        if (wbm_err_i) begin
          stat_d = ST_ERR; tcnt_d = 16'd0; state_d = S_DROP;
        end else if (wbm_ack_i) begin
          stat_d = ST_OK; tcnt_d = 16'd0; state_d = S_DROP;
          if (!wr_q) rdat_d = wbm_dat_i;
        end else if (t_last) begin
          stat_d = ST_TO; tcnt_d = 16'd0; state_d = S_DROP;
        end
      end
      S_DROP: begin
        // let a slave that holds ack until stb falls release it before the
        // next frame; a stuck ack only costs TIMEOUT cycles
        tcnt_d = tcnt_q + 16'd1;
        if (!wbm_ack_i || t_last) state_d = S_STAT;
      end
      S_STAT: if (tx_fire) begin
        bcnt_d  = 8'd0;
        state_d = (stat_q == ST_OK && !wr_q) ? S_RDAT : S_IDLE;
      end
      S_RDAT: if (tx_fire) begin
        rdat_d = rdat_q << 8;
        bcnt_d = bcnt_q + 8'd1;
        if (bcnt_q == 8'(DB - 1)) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q  <= S_IDLE;
      bcnt_q   <= '0;
      tcnt_q   <= '0;
      wr_q     <= 1'b0;
      stat_q   <= '0;
      adr_q    <= '0;
      wdat_q   <= '0;
      rdat_q   <= '0;
      rx_rdy_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      bcnt_q   <= bcnt_d;
      tcnt_q   <= tcnt_d;
      wr_q     <= wr_d;
      stat_q   <= stat_d;
      adr_q    <= adr_d;
      wdat_q   <= wdat_d;
      rdat_q   <= rdat_d;
      // registered from next state so ready tracks the parser with no bubble
      rx_rdy_q <= (state_d == S_IDLE) || (state_d == S_ADDR) || (state_d == S_DATA);
    end
  end

  assign rx_ready_o = rx_rdy_q;
  assign wbm_cyc_o  = (state_q == S_BUS);
  assign wbm_stb_o  = (state_q == S_BUS);
  assign wbm_we_o   = (state_q == S_BUS) & wr_q;
  assign wbm_sel_o  = '1;
  assign wbm_adr_o  = adr_q[BUS_ADDR_WIDTH-1:0];
  assign wbm_dat_o  = wdat_q;
  assign tx_valid_o = (state_q == S_STAT) || (state_q == S_RDAT);

  always_comb begin
    tx_data_o = 8'h00;
    if (state_q == S_STAT)      tx_data_o = stat_q;
    else if (state_q == S_RDAT) tx_data_o = rdat_q[BUS_DATA_WIDTH-1 -: 8];
  end

endmodule

// File: tb/tb_wbm_byte_cmd.sv
module tb_wbm_byte_cmd;
  localparam int DW = 32;
  localparam int AW = 8;
  localparam int TO = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [7:0]    rx_data = 8'h00;
  logic          rx_valid = 1'b0;
  logic          rx_ready;
  logic [7:0]    tx_data;
  logic          tx_valid;
  logic          tx_ready = 1'b1;
  logic          cyc, stb, we;
  logic [3:0]    sel;
  logic [AW-1:0] adr;
  logic [DW-1:0] dat_o;
  logic [DW-1:0] dat_i = '0;
  logic          ack = 1'b0;
  logic          err = 1'b0;

  wbm_byte_cmd #(.BUS_DATA_WIDTH(DW), .BUS_ADDR_WIDTH(AW), .TIMEOUT(TO)) dut (
    .wb_clk_i(clk), .wb_rst_i(rst),
    .rx_data_i(rx_data), .rx_valid_i(rx_valid), .rx_ready_o(rx_ready),
    .tx_data_o(tx_data), .tx_valid_o(tx_valid), .tx_ready_i(tx_ready),
    .wbm_cyc_o(cyc), .wbm_stb_o(stb), .wbm_we_o(we), .wbm_sel_o(sel),
    .wbm_adr_o(adr), .wbm_dat_o(dat_o), .wbm_dat_i(dat_i),
    .wbm_ack_i(ack), .wbm_err_i(err)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // slave behaviour: 0 ack, 1 never respond, 2 ack+err, 3 err only;
  // responds in the (s_dly+1)-th stb cycle and holds until stb falls
  int          s_mode = 0;
  int          s_dly  = 0;
  logic [31:0] s_rdata = '0;

  int          stb_cyc = 0;
  int          txn_cnt = 0;
  int          scnt = 0;
  logic [7:0]  cap_adr = '0;
  logic [31:0] cap_dat = '0;
  logic        cap_we = 1'b0;
  logic [3:0]  cap_sel = '0;

  logic [7:0]  txlog [0:4095];
  int          tx_n = 0;
  int          hold_viol = 0;
  logic        stall_q = 1'b0;
  logic [7:0]  stall_d = '0;

  logic [7:0]  frame [0:5];
  logic [7:0]  exp_b [0:7];
  int          exp_n = 0;
  int          exp_stb = 0;
  bit          exp_bus = 1'b0;

  always @(negedge clk) begin
    if (stb) begin
      if (scnt == 0) begin
        cap_adr = adr; cap_we = we; cap_sel = sel; cap_dat = dat_o;
        txn_cnt++;
      end
      stb_cyc++;
      if (s_mode != 1 && scnt == s_dly) begin
        ack   = (s_mode == 0 || s_mode == 2);
        err   = (s_mode >= 2);
        dat_i = s_rdata;
      end
      scnt++;
    end else begin
      ack = 1'b0; err = 1'b0; scnt = 0;
    end
    if (tx_valid && tx_ready) begin
      txlog[tx_n[11:0]] = tx_data;
      tx_n++;
    end
    if (stall_q && (!tx_valid || tx_data !== stall_d)) hold_viol++;
    stall_q = tx_valid && !tx_ready;
    stall_d = tx_data;
  end

  // expected response stream and bus activity from the command rules
  function automatic void model(input logic [7:0] op, input int mode, input int dly,
                                input logic [31:0] rd);
    exp_n   = 0;
    exp_stb = 0;
    exp_bus = (op == 8'h01 || op == 8'h02);
    if (!exp_bus) begin
      exp_b[0] = 8'hE1; exp_n = 1;
      return;
    end
    if (mode == 1 || dly >= TO) begin
      exp_b[0] = 8'hE0; exp_n = 1; exp_stb = TO;
    end else begin
      exp_stb = dly + 1;
      if (mode >= 2) begin
        exp_b[0] = 8'hEE; exp_n = 1;
      end else begin
        exp_b[0] = 8'hA5; exp_n = 1;
        if (op == 8'h02)
          for (int k = 0; k < 4; k++) begin
            exp_b[1+k] = rd[31-8*k -: 8];
            exp_n++;
          end
      end
    end
  endfunction

  task automatic send_frame(input int len, input bit gaps, output bit ok);
    int t;
    int g;
    ok = 1'b1;
    for (int i = 0; i < len; i++) begin
      g = gaps ? int'($urandom_range(0, 2)) : 0;
      rx_valid = 1'b0;
      repeat (g) begin @(posedge clk); #1; end
      rx_valid = 1'b1;
      rx_data  = frame[i];
      for (t = 0; t < 50; t++) begin
        @(negedge clk);
        if (rx_ready) break;
      end
      @(posedge clk); #1;
      if (t == 50) begin
        n_tests++; n_fail++;
        $display("FAIL rx_accept: byte %0d not taken within 50 cycles, required rx_ready_o=1", i);
        ok = 1'b0;
        break;
      end
    end
    rx_valid = 1'b0;
  endtask

  task automatic collect(input int t0, input int n, input bit rnd);
    int c;
    for (c = 0; c < 300; c++) begin
      @(posedge clk); #1;
      if (tx_n - t0 >= n) break;
      tx_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
    end
    if (c == 300) begin
      n_tests++; n_fail++;
      $display("FAIL tx_wait: got %0d bytes after 300 cycles, required %0d", tx_n - t0, n);
    end
    tx_ready = 1'b1;
    repeat (15) @(posedge clk);
    #1;
  endtask

  task automatic do_txn(input string nm, input logic [7:0] op, input logic [7:0] a,
                        input logic [31:0] wd, input int mode, input int dly,
                        input logic [31:0] rd, input bit gaps, input bit rnd);
    int  t0, c0, s0, h0, len, got, cyc_used;
    time ts;
    bit  ok;
    s_mode = mode; s_dly = dly; s_rdata = rd;
    frame[0] = op; frame[1] = a;
    frame[2] = wd[31:24]; frame[3] = wd[23:16]; frame[4] = wd[15:8]; frame[5] = wd[7:0];
    len = (op == 8'h01) ? 6 : (op == 8'h02) ? 2 : 1;
    model(op, mode, dly, rd);
    t0 = tx_n; c0 = txn_cnt; s0 = stb_cyc; h0 = hold_viol;
    ts = $time;
    send_frame(len, gaps, ok);
    if (!gaps && ok) begin
      cyc_used = int'(($time - ts) / 10);
      n_tests++;
      if (cyc_used != len) begin
        n_fail++;
        $display("FAIL %s rx_rate: frame took %0d cycles, required %0d", nm, cyc_used, len);
      end
    end
    if (exp_bus) begin
      n_tests++;
      if ({cyc, stb} !== 2'b11) begin
        n_fail++;
        $display("FAIL %s stb_latency: cyc,stb=%b one cycle after last byte, required 11", nm, {cyc, stb});
      end
    end
    collect(t0, exp_n, rnd);
    got = tx_n - t0;
    n_tests++;
    if (got != exp_n) begin
      n_fail++;
      $display("FAIL %s tx_count: got %0d bytes, required %0d", nm, got, exp_n);
    end
    for (int i = 0; i < exp_n && i < got; i++) begin
      n_tests++;
      if (txlog[(t0 + i) % 4096] !== exp_b[i]) begin
        n_fail++;
        $display("FAIL %s tx_byte[%0d]: got %h, required %h", nm, i, txlog[(t0 + i) % 4096], exp_b[i]);
      end
    end
    n_tests++;
    if (txn_cnt - c0 != (exp_bus ? 1 : 0)) begin
      n_fail++;
      $display("FAIL %s bus_txns: got %0d, required %0d", nm, txn_cnt - c0, exp_bus ? 1 : 0);
    end
    n_tests++;
    if (hold_viol != h0) begin
      n_fail++;
      $display("FAIL %s tx_hold: %0d stalled bytes changed or dropped, required 0", nm, hold_viol - h0);
    end
    if (exp_bus) begin
      n_tests++;
      if (cap_adr !== a || cap_we !== (op == 8'h01) || cap_sel !== 4'hF) begin
        n_fail++;
        $display("FAIL %s bus_req: adr=%h we=%b sel=%h, required adr=%h we=%b sel=f",
                 nm, cap_adr, cap_we, cap_sel, a, op == 8'h01);
      end
      if (op == 8'h01) begin
        n_tests++;
        if (cap_dat !== wd) begin
          n_fail++;
          $display("FAIL %s bus_wdata: got %h, required %h", nm, cap_dat, wd);
        end
      end
      n_tests++;
      if (stb_cyc - s0 != exp_stb) begin
        n_fail++;
        $display("FAIL %s stb_cycles: got %0d, required %0d", nm, stb_cyc - s0, exp_stb);
      end
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_tests++;
    if ({cyc, stb, we} !== 3'b000) begin
      n_fail++; $display("FAIL reset_bus_ctl: cyc,stb,we=%b, required 000", {cyc, stb, we});
    end
    n_tests++;
    if (sel !== 4'hF) begin
      n_fail++; $display("FAIL reset_sel: got %h, required f", sel);
    end
    n_tests++;
    if (adr !== '0 || dat_o !== '0) begin
      n_fail++; $display("FAIL reset_adr_dat: adr=%h dat=%h, required 0 0", adr, dat_o);
    end
    n_tests++;
    if (tx_valid !== 1'b0 || tx_data !== 8'h00) begin
      n_fail++; $display("FAIL reset_tx: valid=%b data=%h, required 0 00", tx_valid, tx_data);
    end
    n_tests++;
    if (rx_ready !== 1'b0) begin
      n_fail++; $display("FAIL reset_rx_ready: got %b, required 0", rx_ready);
    end
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_tests++;
    if (rx_ready !== 1'b1) begin
      n_fail++; $display("FAIL idle_rx_ready: got %b, required 1", rx_ready);
    end
  endtask

  task automatic test_write;
    do_txn("write", 8'h01, 8'h00, 32'hDEADBEEF, 0, 0, 32'h0, 1'b0, 1'b0);
    do_txn("write_slow", 8'h01, 8'hC3, 32'h01020304, 0, 4, 32'h0, 1'b0, 1'b0);
  endtask

  task automatic test_read;
    do_txn("read", 8'h02, 8'h00, 32'h0, 0, 2, 32'h12345678, 1'b0, 1'b0);
  endtask

  task automatic test_timeout;
    do_txn("timeout", 8'h02, 8'h33, 32'h0, 1, 0, 32'hAAAA5555, 1'b0, 1'b0);
    do_txn("ack_last_cycle", 8'h02, 8'h34, 32'h0, 0, TO - 1, 32'hCAFEF00D, 1'b0, 1'b0);
  endtask

  task automatic test_error;
    do_txn("err_ack_read", 8'h02, 8'h10, 32'h0, 2, 1, 32'h87654321, 1'b0, 1'b0);
    do_txn("err_write", 8'h01, 8'h11, 32'h55AA55AA, 3, 0, 32'h0, 1'b0, 1'b0);
  endtask

  task automatic test_backpressure;
    int  t0, h0, c;
    bit  ok;
    s_mode = 0; s_dly = 2; s_rdata = 32'h12345678;
    frame[0] = 8'h02; frame[1] = 8'h10;
    t0 = tx_n; h0 = hold_viol;
    send_frame(2, 1'b0, ok);
    for (c = 0; c < 100; c++) begin
      @(posedge clk); #1;
      if (tx_n - t0 >= 2) break;
    end
    tx_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      n_tests++;
      if (tx_valid !== 1'b1 || tx_data !== 8'h34) begin
        n_fail++;
        $display("FAIL bp_stall[%0d]: valid=%b data=%h, required 1 34", i, tx_valid, tx_data);
      end
      @(posedge clk); #1;
    end
    tx_ready = 1'b1;
    collect(t0, 5, 1'b0);
    n_tests++;
    if (tx_n - t0 != 5) begin
      n_fail++; $display("FAIL bp_count: got %0d bytes, required 5", tx_n - t0);
    end
    n_tests++;
    if ({txlog[t0 % 4096], txlog[(t0+1) % 4096], txlog[(t0+2) % 4096],
         txlog[(t0+3) % 4096], txlog[(t0+4) % 4096]} !== 40'hA512345678) begin
      n_fail++;
      $display("FAIL bp_bytes: got %h %h %h %h %h, required a5 12 34 56 78",
               txlog[t0 % 4096], txlog[(t0+1) % 4096], txlog[(t0+2) % 4096],
               txlog[(t0+3) % 4096], txlog[(t0+4) % 4096]);
    end
    n_tests++;
    if (hold_viol != h0) begin
      n_fail++; $display("FAIL bp_hold: %0d hold violations, required 0", hold_viol - h0);
    end
  endtask

  task automatic test_bad_op;
    do_txn("bad_op_7f", 8'h7F, 8'h00, 32'h0, 0, 0, 32'h0, 1'b0, 1'b0);
    do_txn("bad_op_00", 8'h00, 8'h00, 32'h0, 0, 0, 32'h0, 1'b0, 1'b0);
  endtask

  task automatic test_reset_mid_bus;
    int  t0;
    bit  ok;
    s_mode = 1; s_dly = 0;
    frame[0] = 8'h02; frame[1] = 8'h42;
    t0 = tx_n;
    send_frame(2, 1'b0, ok);
    repeat (2) @(posedge clk);
    #1;
    n_tests++;
    if (stb !== 1'b1) begin
      n_fail++; $display("FAIL rst_mid_pre: stb=%b, required 1", stb);
    end
    rst = 1'b1;
    @(posedge clk); #1;
    n_tests++;
    if ({cyc, stb, tx_valid} !== 3'b000) begin
      n_fail++; $display("FAIL rst_mid_bus: cyc,stb,tx_valid=%b, required 000", {cyc, stb, tx_valid});
    end
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_tests++;
    if (rx_ready !== 1'b1 || tx_valid !== 1'b0 || tx_n != t0) begin
      n_fail++;
      $display("FAIL rst_mid_idle: rx_ready=%b tx_valid=%b tx_bytes=%0d, required 1 0 0",
               rx_ready, tx_valid, tx_n - t0);
    end
    do_txn("after_reset", 8'h01, 8'h5A, 32'hFEEDFACE, 0, 1, 32'h0, 1'b0, 1'b0);
  endtask

  task automatic test_random;
    logic [7:0]  op;
    int          r;
    for (int i = 0; i < 40; i++) begin
      r = int'($urandom_range(0, 9));
      if (r < 4)      op = 8'h01;
      else if (r < 8) op = 8'h02;
      else begin
        op = 8'($urandom);
        if (op == 8'h01 || op == 8'h02) op = 8'hFF;
      end
      do_txn("random", op, 8'($urandom), $urandom, int'($urandom_range(0, 3)),
             int'($urandom_range(0, TO - 1)), $urandom, 1'($urandom_range(0, 1)), 1'b1);
    end
  endtask

  initial begin
    test_reset;
    test_write;
    test_read;
    test_timeout;
    test_error;
    test_backpressure;
    test_bad_op;
    test_reset_mid_bus;
    test_random;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
